instmem_ctrl: RTL and testbench
===============================

Name: instmem_ctrl

Overview:
Parametrised instruction memory with two interfaces: a built-in block-load engine and a registered fetch port.
- Load engine: accepts a stream of instruction words through a valid/ready handshake and writes them to consecutive addresses from a programmed base.
- Fetch port: serves CPU instruction reads with fixed 1-cycle latency.
- Adds range checking, load/fetch arbitration and status flags.
- Sits between the boot/debug loader and the CPU fetch stage.

Parameters:
DW, 19, instruction word width.
AW, 14, address width of load and fetch addresses.
DEPTH, 256, number of implemented words; must be ≤ 2^AW; valid addresses are 0..DEPTH-1.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
load_start  input  1  start a block load (sampled in IDLE only).
load_base  input  AW  first write address, latched on accepted load_start.
load_len  input  AW+1  number of words to load, latched on accepted load_start.
ld_valid  input  1  ld_data holds a word.
ld_data  input  DW  instruction word to write.
ld_ready  output  1  engine accepts a word this cycle.
load_busy  output  1  high while state is LOAD.
load_done  output  1  sticky: last block load completed.
load_err  output  1  sticky: last load_start rejected (range overflow).
load_cnt  output  AW+1  words written in current/last load.
fetch_req  input  1  fetch request.
fetch_addr  input  AW  fetch address.
fetch_data  output  DW  fetched instruction.
fetch_valid  output  1  fetch_data valid this cycle.
fetch_err  output  1  1-cycle pulse with fetch_valid: address out of range.

Behaviour:
- Reset values:
  - state = IDLE.
  - ld_ready, load_busy, load_done, load_err, fetch_valid, fetch_err = 0.
  - load_cnt = 0; fetch_data = 0.
  - Memory contents are not reset.
- States: IDLE, LOAD.
- IDLE, load_start = 1: clear load_done, load_err, load_cnt; then check the range.
  - load_base + load_len > DEPTH (computed at AW+2 bits, no wrap): set load_err, stay IDLE, write nothing.
  - load_len = 0: set load_done next cycle, stay IDLE.
  - Otherwise: latch ptr = load_base, rem = load_len; go to LOAD next cycle.
- LOAD:
  - ld_ready = 1 and load_busy = 1 for the whole state.
  - Each cycle with ld_valid = 1: mem[ptr] = ld_data, ptr+1, rem-1, load_cnt+1.
  - Cycles with ld_valid = 0 are stalls; no state changes.
  - When the word with rem = 1 is written: go to IDLE next cycle, set load_done; ld_ready drops in that same next cycle.
  - load_start while in LOAD is ignored.
- Fetch:
  - Served only in IDLE.
  - fetch_req = 1 in cycle N gives fetch_valid = 1 in cycle N+1, with fetch_data = mem[fetch_addr] sampled at edge N.
  - fetch_addr ≥ DEPTH: fetch_data = 0 and fetch_err = 1 alongside fetch_valid.
  - fetch_valid = 0 when there is no request; fetch_data holds its last value.
- Arbitration:
  - fetch_req during LOAD is dropped: fetch_valid stays 0. The CPU must retry while load_busy = 1.
  - load_start and fetch_req in the same IDLE cycle: the fetch is served with pre-load contents, and LOAD begins next cycle.
- Read-during-write cannot occur, because fetches are blocked in LOAD.
- Reset mid-load:
  - Returns to IDLE; load_done = 0, load_cnt = 0.
  - Already-written words are retained.
  - Any pending fetch_valid is cancelled.
- Sticky flags persist until the next accepted load_start or rst.

Test Plan:
- Reset, then fetch addr 5 → fetch_valid = 1 one cycle later; all status outputs 0 during reset.
- Block load: base = 10, len = 4, words 0x00001..0x00004 with ld_valid stalled one cycle after word 2 → ld_ready high for 5 cycles; load_done = 1, load_cnt = 4; fetches of 10..13 return 0x00001..0x00004, each fetch_valid 1 cycle after its req.
- Boundary load: base = 250, len = 6 → accepted, writes 250..255; base = 250, len = 7 → load_err = 1, state stays IDLE, mem[250] unchanged.
- Fetch 0x0100 (DEPTH = 256) → fetch_valid = 1, fetch_err = 1, fetch_data = 0.
- fetch_req during LOAD → no fetch_valid. Same-cycle load_start + fetch of addr 10 (holding 0x00001) → fetch returns 0x00001; a new load of 0x7FFFF to addr 10 then reads back 0x7FFFF.
- rst asserted after 2 of 4 words → IDLE, load_done = 0, load_cnt = 0; the first 2 words read back and the remaining 2 keep their old contents. load_len = 0 → load_done next cycle, no writes.

Source files
------------

// File: rtl/instmem_ctrl.sv
// Instruction memory with a streaming block-load engine and a 1-cycle fetch port.
// Loads and fetches are mutually exclusive: fetches are only served while the engine is idle.
module instmem_ctrl #(
  parameter int DW    = 19,
  parameter int AW    = 14,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW-1:0] load_base,
  input  logic [AW:0]   load_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   load_cnt,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_valid,
  output logic          fetch_err,
  output logic [0:0]    dbgState
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW+1:0] DepthW = (AW+2)'(DEPTH);

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [AW:0]   rem;
  logic [DW-1:0] mem [DEPTH];

  logic [AW+1:0] loadEnd;
  logic          rangeErr;
  logic          zeroLen;
  logic          wrEn;
  logic          lastWord;
  logic          fetchHit;
  logic          fetchInRange;

  // Range check is done two bits wider than the address so base+len cannot wrap.
  assign loadEnd      = {2'b00, load_base} + {1'b0, load_len};
  assign rangeErr     = loadEnd > DepthW;
  assign zeroLen      = load_len == '0;
  assign lastWord     = rem == (AW+1)'(1);
  assign fetchHit     = (state == IDLE) && fetch_req;
  assign fetchInRange = {2'b00, fetch_addr} < DepthW;

  // A word transfers on every rising edge where ld_valid and ld_ready are both high;
  // ld_ready depends only on state, never on ld_valid, and the source may stall freely.
  assign ld_ready  = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign wrEn      = (state == LOAD) && ld_valid && !rst;
  assign dbgState  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      load_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            load_err  <= rangeErr;
            load_done <= !rangeErr && zeroLen;
            load_cnt  <= '0;
            if (!rangeErr && !zeroLen) begin
              state <= LOAD;
              ptr   <= load_base[IW-1:0];
              rem   <= load_len;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr      <= ptr + IW'(1);
            rem      <= rem - (AW+1)'(1);
            load_cnt <= load_cnt + (AW+1)'(1);
            if (lastWord) begin
              state     <= IDLE;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset so it can map onto plain RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetchHit;
      fetch_err   <= fetchHit && !fetchInRange;
      if (fetchHit) begin
        fetch_data <= fetchInRange ? mem[fetch_addr[IW-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_instmem_ctrl.sv
// Self-checking bench for instmem_ctrl: scenario tasks against a word-array memory model.
module tb_instmem_ctrl;
  localparam int DW    = 19;
  localparam int AW    = 14;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_cnt;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          fetch_err;
  logic [0:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] wq [$];

  instmem_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err), .load_cnt(load_cnt),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_err(fetch_err), .dbgState(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int base, input int len);
    load_start = 1'b1;
    load_base  = AW'(base);
    load_len   = (AW+1)'(len);
    step();
    load_start = 1'b0;
  endtask

  task automatic feed_words(input int stall_at, input bit rand_stall,
                            output int ready_cyc, output bit timeout);
    int idx;
    int budget;
    bit stalled;
    bit was_ready;
    idx = 0; budget = 0; stalled = 0; ready_cyc = 0; timeout = 0;
    while (idx < wq.size() && !timeout) begin
      was_ready = ld_ready;
      if (was_ready) ready_cyc++;
      if (idx == stall_at && !stalled) begin
        ld_valid = 1'b0;
        stalled  = 1'b1;
      end else if (rand_stall && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
      end
      ld_data = wq[idx];
      step();
      if (ld_valid && was_ready) idx++;
      budget++;
      if (budget > 500) timeout = 1'b1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic fetch_once(input int a, output logic v, output logic e, output logic [DW-1:0] d);
    fetch_req  = 1'b1;
    fetch_addr = AW'(a);
    step();
    fetch_req = 1'b0;
    v = fetch_valid;
    e = fetch_err;
    d = fetch_data;
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
  endtask

  task automatic model_write(input int base);
    for (int i = 0; i < wq.size(); i++) begin
      model_mem[base + i] = wq[i];
      known[base + i]     = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic v, e;
    logic [DW-1:0] d;
    rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    load_base = '0; load_len = '0;
    fetch_req = 1'b1; fetch_addr = AW'(5);
    step(); step();
    checks++;
    if ({ld_ready, load_busy, load_done, load_err, fetch_valid, fetch_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {ld_ready, load_busy, load_done, load_err, fetch_valid, fetch_err});
    end
    checks++;
    if (load_cnt !== '0 || fetch_data !== '0) begin
      errors++;
      $display("FAIL reset_values: load_cnt %0d fetch_data %h expected 0 and 0", load_cnt, fetch_data);
    end
    rst = 1'b0; fetch_req = 1'b0;
    fetch_once(5, v, e, d);
    checks++;
    if ({v, e} !== 2'b10) begin
      errors++;
      $display("FAIL reset_fetch5: valid/err got %b expected 10", {v, e});
    end
  endtask

  task automatic test_block_load();
    int rc;
    bit to;
    logic v, e;
    logic [DW-1:0] d;
    wq = '{19'h00001, 19'h00002, 19'h00003, 19'h00004};
    start_load(10, 4);
    checks++;
    if ({ld_ready, load_busy, load_done, load_err} !== 4'b1100 || load_cnt !== '0) begin
      errors++;
      $display("FAIL block_enter: status %b cnt %0d expected 1100 cnt 0",
               {ld_ready, load_busy, load_done, load_err}, load_cnt);
    end
    feed_words(2, 1'b0, rc, to);
    checks++;
    if (to || rc !== 5) begin
      errors++;
      $display("FAIL block_ready_cycles: got %0d (timeout %0d) expected 5", rc, to);
    end
    checks++;
    if ({ld_ready, load_busy, load_done, load_err} !== 4'b0010 || load_cnt !== (AW+1)'(4)) begin
      errors++;
      $display("FAIL block_done: status %b cnt %0d expected 0010 cnt 4",
               {ld_ready, load_busy, load_done, load_err}, load_cnt);
    end
    model_write(10);
    for (int i = 0; i < 4; i++) begin
      fetch_once(10 + i, v, e, d);
      checks++;
      if ({v, e} !== 2'b10 || d !== model_mem[10 + i]) begin
        errors++;
        $display("FAIL block_fetch[%0d]: valid/err %b data %h expected 10 data %h",
                 10 + i, {v, e}, d, model_mem[10 + i]);
      end
    end
  endtask

  task automatic test_boundary();
    int rc;
    bit to;
    logic v, e;
    logic [DW-1:0] d;
    logic [DW-1:0] old250;
    fill_random(6);
    start_load(250, 6);
    feed_words(-1, 1'b1, rc, to);
    checks++;
    if (to || {load_busy, load_done, load_err} !== 3'b010 || load_cnt !== (AW+1)'(6)) begin
      errors++;
      $display("FAIL bound_accept: busy/done/err %b cnt %0d timeout %0d expected 010 cnt 6",
               {load_busy, load_done, load_err}, load_cnt, to);
    end
    model_write(250);
    old250 = model_mem[250];
    ld_valid = 1'b1; ld_data = ~old250;
    start_load(250, 7);
    checks++;
    if ({ld_ready, load_busy, load_done, load_err} !== 4'b0001 || load_cnt !== '0) begin
      errors++;
      $display("FAIL bound_reject: status %b cnt %0d expected 0001 cnt 0",
               {ld_ready, load_busy, load_done, load_err}, load_cnt);
    end
    step();
    ld_valid = 1'b0;
    checks++;
    if ({load_busy, load_err} !== 2'b01) begin
      errors++;
      $display("FAIL bound_sticky: busy/err %b expected 01", {load_busy, load_err});
    end
    fetch_once(250, v, e, d);
    checks++;
    if ({v, e} !== 2'b10 || d !== old250) begin
      errors++;
      $display("FAIL bound_mem250: valid/err %b data %h expected 10 data %h", {v, e}, d, old250);
    end
    fetch_once(255, v, e, d);
    checks++;
    if ({v, e} !== 2'b10 || d !== model_mem[255]) begin
      errors++;
      $display("FAIL bound_mem255: valid/err %b data %h expected 10 data %h", {v, e}, d, model_mem[255]);
    end
  endtask

  task automatic test_fetch_oob();
    logic v, e;
    logic [DW-1:0] d;
    fetch_once(256, v, e, d);
    checks++;
    if ({v, e} !== 2'b11 || d !== '0) begin
      errors++;
      $display("FAIL oob_256: valid/err %b data %h expected 11 data 0", {v, e}, d);
    end
    fetch_once(16383, v, e, d);
    checks++;
    if ({v, e} !== 2'b11 || d !== '0) begin
      errors++;
      $display("FAIL oob_3fff: valid/err %b data %h expected 11 data 0", {v, e}, d);
    end
    fetch_once(255, v, e, d);
    checks++;
    if ({v, e} !== 2'b10 || d !== model_mem[255]) begin
      errors++;
      $display("FAIL oob_recover: valid/err %b data %h expected 10 data %h", {v, e}, d, model_mem[255]);
    end
    step();
    checks++;
    if ({fetch_valid, fetch_err} !== 2'b00 || fetch_data !== model_mem[255]) begin
      errors++;
      $display("FAIL fetch_hold: valid/err %b data %h expected 00 data %h",
               {fetch_valid, fetch_err}, fetch_data, model_mem[255]);
    end
  endtask

  task automatic test_arbitration();
    int rc;
    bit to;
    logic v, e;
    logic [DW-1:0] d;
    fetch_req = 1'b1; fetch_addr = AW'(10);
    start_load(10, 1);
    fetch_addr = AW'(11);
    checks++;
    if ({fetch_valid, fetch_err} !== 2'b10 || fetch_data !== model_mem[10]) begin
      errors++;
      $display("FAIL arb_same_cycle: valid/err %b data %h expected 10 data %h",
               {fetch_valid, fetch_err}, fetch_data, model_mem[10]);
    end
    checks++;
    if ({load_busy, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL arb_load_started: busy/err %b expected 10", {load_busy, load_err});
    end
    step();
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL arb_drop_stall: fetch_valid %b expected 0", fetch_valid);
    end
    wq = '{19'h7FFFF};
    feed_words(-1, 1'b0, rc, to);
    fetch_req = 1'b0;
    checks++;
    if (to || fetch_valid !== 1'b0 || load_done !== 1'b1 || load_cnt !== (AW+1)'(1)) begin
      errors++;
      $display("FAIL arb_drop_last: valid %b done %b cnt %0d timeout %0d expected 0 1 1",
               fetch_valid, load_done, load_cnt, to);
    end
    model_write(10);
    fetch_once(10, v, e, d);
    checks++;
    if ({v, e} !== 2'b10 || d !== 19'h7FFFF) begin
      errors++;
      $display("FAIL arb_readback: valid/err %b data %h expected 10 data 7ffff", {v, e}, d);
    end
  endtask

  task automatic test_reset_mid_load();
    int rc;
    bit to;
    logic v, e;
    logic [DW-1:0] d;
    logic [DW-1:0] nw [4];
    fill_random(4);
    start_load(100, 4);
    feed_words(-1, 1'b1, rc, to);
    model_write(100);
    for (int i = 0; i < 4; i++) nw[i] = DW'($urandom);
    start_load(100, 4);
    ld_valid = 1'b1; ld_data = nw[0];
    step();
    ld_data = nw[1];
    step();
    checks++;
    if (load_cnt !== (AW+1)'(2)) begin
      errors++;
      $display("FAIL rml_cnt2: got %0d expected 2", load_cnt);
    end
    ld_data = nw[2]; rst = 1'b1;
    step();
    rst = 1'b0; ld_valid = 1'b0;
    model_mem[100] = nw[0];
    model_mem[101] = nw[1];
    checks++;
    if ({ld_ready, load_busy, load_done, load_err} !== 4'b0000 || load_cnt !== '0) begin
      errors++;
      $display("FAIL rml_status: status %b cnt %0d expected 0000 cnt 0",
               {ld_ready, load_busy, load_done, load_err}, load_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      fetch_once(100 + i, v, e, d);
      checks++;
      if ({v, e} !== 2'b10 || d !== model_mem[100 + i]) begin
        errors++;
        $display("FAIL rml_fetch[%0d]: valid/err %b data %h expected 10 data %h",
                 100 + i, {v, e}, d, model_mem[100 + i]);
      end
    end
    fetch_req = 1'b1; fetch_addr = AW'(100); rst = 1'b1;
    step();
    rst = 1'b0; fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== '0) begin
      errors++;
      $display("FAIL rml_fetch_cancel: valid %b data %h expected 0 data 0", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_zero_len();
    logic v, e;
    logic [DW-1:0] d;
    ld_valid = 1'b1; ld_data = ~model_mem[100];
    start_load(100, 0);
    ld_valid = 1'b0;
    checks++;
    if ({ld_ready, load_busy, load_done, load_err} !== 4'b0010 || load_cnt !== '0) begin
      errors++;
      $display("FAIL zero_len: status %b cnt %0d expected 0010 cnt 0",
               {ld_ready, load_busy, load_done, load_err}, load_cnt);
    end
    step();
    checks++;
    if ({load_busy, load_done} !== 2'b01) begin
      errors++;
      $display("FAIL zero_len_sticky: busy/done %b expected 01", {load_busy, load_done});
    end
    fetch_once(100, v, e, d);
    checks++;
    if ({v, e} !== 2'b10 || d !== model_mem[100]) begin
      errors++;
      $display("FAIL zero_len_nowrite: valid/err %b data %h expected 10 data %h", {v, e}, d, model_mem[100]);
    end
  endtask

  task automatic test_random();
    int base, len, rc, a;
    bit to, ovf;
    logic [3:0] exp_st;
    logic v, e;
    logic [DW-1:0] d;
    for (int it = 0; it < 10; it++) begin
      base = $urandom_range(0, 270);
      len  = $urandom_range(0, 24);
      ovf  = (base + len) > DEPTH;
      fill_random(len);
      start_load(base, len);
      if (ovf) exp_st = 4'b0001;
      else if (len == 0) exp_st = 4'b0010;
      else exp_st = 4'b1100;
      checks++;
      if ({ld_ready, load_busy, load_done, load_err} !== exp_st || load_cnt !== '0) begin
        errors++;
        $display("FAIL rand_start[%0d] base %0d len %0d: status %b cnt %0d expected %b cnt 0",
                 it, base, len, {ld_ready, load_busy, load_done, load_err}, load_cnt, exp_st);
      end
      if (!ovf && len != 0) begin
        feed_words(-1, 1'b1, rc, to);
        checks++;
        if (to || {ld_ready, load_busy, load_done, load_err} !== 4'b0010 || load_cnt !== (AW+1)'(len)) begin
          errors++;
          $display("FAIL rand_done[%0d]: status %b cnt %0d timeout %0d expected 0010 cnt %0d",
                   it, {ld_ready, load_busy, load_done, load_err}, load_cnt, to, len);
        end
        model_write(base);
      end
      for (int k = 0; k < 6; k++) begin
        a = (k < 2 && !ovf && len != 0) ? base + $urandom_range(0, len - 1) : $urandom_range(0, 300);
        fetch_once(a, v, e, d);
        checks++;
        if ({v, e} !== {1'b1, (a >= DEPTH)}) begin
          errors++;
          $display("FAIL rand_fetch_flags[%0d]: valid/err %b expected 1%b", a, {v, e}, (a >= DEPTH));
        end
        if (a >= DEPTH || known[a]) begin
          checks++;
          if (d !== ((a >= DEPTH) ? '0 : model_mem[a])) begin
            errors++;
            $display("FAIL rand_fetch_data[%0d]: got %h expected %h", a, d,
                     (a >= DEPTH) ? '0 : model_mem[a]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset();
    test_block_load();
    test_boundary();
    test_fetch_oob();
    test_arbitration();
    test_reset_mid_load();
    test_zero_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
